seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment controller: sequential binary-to-BCD conversion
// (shift-add-3), leading-zero blanking, overflow dashes and a free-running digit scan.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BIN_W-1:0]        value,
  output logic                    busy,
  output logic                    ovf,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7*NUM_DIGITS-1:0] dig_seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CMP_W = (BIN_W > 30) ? BIN_W : 30;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(10 ** NUM_DIGITS - 1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t                 state;
  logic [BIN_W-1:0]       bin_sr;
  logic [BCD_W-1:0]       bcd_work;
  logic [BCD_W-1:0]       disp_bcd;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   ovf_next;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_next;
  logic [BIN_W-1:0]       bin_next;

  logic [DIV_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]       scan_idx;
  logic [IDX_W-1:0]       idx_next;
  logic                   scan_wrap;
  logic                   lz_run;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0011000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
    shifted  = {bcd_adj, bin_sr} << 1;
    bcd_next = shifted[BCD_W+BIN_W-1 -: BCD_W];
    bin_next = shifted[BIN_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      ovf_next <= 1'b0;
      bin_sr   <= '0;
      bcd_work <= '0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr   <= value;
            bcd_work <= '0;
            bit_cnt  <= CNT_W'(BIN_W);
            ovf_next <= (CMP_W'(value) > MAX_VAL);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_work <= bcd_next;
          bin_sr   <= bin_next;
          bit_cnt  <= bit_cnt - CNT_W'(1);
          // Display only changes on the last shift, so it never shows a partial result.
          if (bit_cnt == CNT_W'(1)) begin
            disp_bcd <= bcd_next;
            ovf      <= ovf_next;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Walk from the top digit down so lz_run means "this digit and all above are zero".
  always_comb begin
    dig_seg = '0;
    lz_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (disp_bcd[4*k +: 4] == 4'd0);
      if (ovf)
        dig_seg[7*k +: 7] = SEG_DASH;
      else if ((BLANK_LZ != 0) && (k > 0) && lz_run)
        dig_seg[7*k +: 7] = SEG_BLANK;
      else
        dig_seg[7*k +: 7] = seg_decode(disp_bcd[4*k +: 4]);
    end
  end

  always_comb begin
    scan_wrap = (scan_cnt == DIV_W'(SCAN_DIV - 1));
    idx_next  = scan_idx;
    if (scan_wrap)
      idx_next = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
  end

  // an/seg are registered from the next index so they move together with scan_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= ~NUM_DIGITS'(1);
      seg      <= SEG_ZERO;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + DIV_W'(1);
      scan_idx <= idx_next;
      an       <= ~(NUM_DIGITS'(1) << idx_next);
      seg      <= dig_seg[7*int'(idx_next) +: 7];
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed cases plus random loads,
// compared every cycle against an arithmetic model of the display.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SD = 4;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_DASH  = 7'b0111111;
  localparam logic [6:0] P_ZERO  = 7'b1000000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load = 1'b0;
  logic [BW-1:0]   value = '0;

  logic            busy, ovf, busy_nb, ovf_nb;
  logic [6:0]      seg, seg_nb;
  logic [ND-1:0]   an, an_nb;
  logic [7*ND-1:0] dig_seg, dig_seg_nb;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LZ(1)) u_dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy), .ovf(ovf), .seg(seg), .an(an), .dig_seg(dig_seg)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy_nb), .ovf(ovf_nb), .seg(seg_nb), .an(an_nb), .dig_seg(dig_seg_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'b1000000;
      1: enc = 7'b1111001;
      2: enc = 7'b0100100;
      3: enc = 7'b0110000;
      4: enc = 7'b0011001;
      5: enc = 7'b0010010;
      6: enc = 7'b0000010;
      7: enc = 7'b1111000;
      8: enc = 7'b0000000;
      9: enc = 7'b0011000;
      default: enc = P_BLANK;
    endcase
  endfunction

  // Expected digit patterns from the decimal value itself.
  function automatic logic [7*ND-1:0] exp_digits(input int v, input bit ov, input bit blz);
    logic [7*ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < ND; k++) begin
      if (ov)                       r[7*k +: 7] = P_DASH;
      else if (blz && k > 0 && v < p) r[7*k +: 7] = P_BLANK;
      else                          r[7*k +: 7] = enc((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Behavioural model: a busy countdown and the value currently shown.
  int cyc = 0;
  int m_busy_cnt = 0;
  int m_pend = 0;
  int m_shown = 0;
  bit m_ovf = 1'b0;
  bit rst_edge = 1'b0;
  bit armed = 1'b0;
  logic [7*ND-1:0] prev_lz = '0;
  logic [7*ND-1:0] prev_nb = '0;

  always @(posedge clk) begin
    if (reset) begin
      cyc = 0; m_busy_cnt = 0; m_shown = 0; m_ovf = 1'b0;
      rst_edge = 1'b1; armed = 1'b1;
    end else begin
      cyc++;
      rst_edge = 1'b0;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_shown = m_pend;
          m_ovf   = (m_pend > 10 ** ND - 1);
        end
      end else if (load) begin
        m_pend     = int'(value);
        m_busy_cnt = BW;
      end
    end
  end

  always @(negedge clk) begin
    logic [7*ND-1:0] e_lz, e_nb;
    logic [ND-1:0]   e_an;
    int idx;
    e_lz = exp_digits(m_shown, m_ovf, 1'b1);
    e_nb = exp_digits(m_shown, m_ovf, 1'b0);
    if (armed) begin
      idx  = (cyc / SD) % ND;
      e_an = ~(ND'(1) << idx);
      check("busy",       64'(busy),       64'(m_busy_cnt > 0));
      check("busy_nb",    64'(busy_nb),    64'(m_busy_cnt > 0));
      check("ovf",        64'(ovf),        64'(m_ovf));
      check("ovf_nb",     64'(ovf_nb),     64'(m_ovf));
      check("dig_seg",    64'(dig_seg),    64'(e_lz));
      check("dig_seg_nb", 64'(dig_seg_nb), 64'(e_nb));
      check("an",         64'(an),         64'(e_an));
      check("an_nb",      64'(an_nb),      64'(e_an));
      check("seg",    64'(seg),    64'(rst_edge ? P_ZERO : prev_lz[7*idx +: 7]));
      check("seg_nb", 64'(seg_nb), 64'(rst_edge ? P_ZERO : prev_nb[7*idx +: 7]));
    end
    prev_lz = e_lz;
    prev_nb = e_nb;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse load for one cycle, then count busy cycles (bounded).
  task automatic load_measure(input int v, input int second_at, input int v2, output int n);
    @(negedge clk);
    load = 1'b1;
    value = BW'(v);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      n++;
      load = (n == second_at);
      value = (n == second_at) ? BW'(v2) : value;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    cycles(3);
    reset = 1'b0;
    cycles(24);
    check("idle_busy", 64'(busy), 64'(0));

    load_measure(1234, 0, 0, n);
    check("busy_len_1234", 64'(n), 64'(BW));
    cycles(2);
    check("d1234", 64'(dig_seg), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
    cycles(20);

    load_measure(7, 0, 0, n);
    cycles(2);
    check("d7_lz", 64'(dig_seg),    64'({P_BLANK, P_BLANK, P_BLANK, 7'b1111000}));
    check("d7_nb", 64'(dig_seg_nb), 64'({P_ZERO, P_ZERO, P_ZERO, 7'b1111000}));

    load_measure(0, 0, 0, n);
    cycles(2);
    check("d0_lz", 64'(dig_seg), 64'({P_BLANK, P_BLANK, P_BLANK, P_ZERO}));

    load_measure(10000, 0, 0, n);
    cycles(1);
    check("ovf_10000", 64'(ovf), 64'(1));
    check("d10000", 64'(dig_seg), 64'({4{P_DASH}}));

    load_measure(9999, 0, 0, n);
    cycles(1);
    check("ovf_9999", 64'(ovf), 64'(0));
    check("d9999", 64'(dig_seg), 64'({4{7'b0011000}}));

    load_measure(42, 3, 99, n);
    check("busy_len_42", 64'(n), 64'(BW));
    cycles(3);
    check("d42", 64'(dig_seg), 64'({P_BLANK, P_BLANK, 7'b0011001, 7'b0100100}));

    // Abort a conversion with reset during its fifth busy cycle.
    @(negedge clk);
    load = 1'b1; value = BW'(555);
    @(negedge clk);
    load = 1'b0;
    cycles(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_disp", 64'(dig_seg), 64'({P_BLANK, P_BLANK, P_BLANK, P_ZERO}));
    check("abort_ovf", 64'(ovf), 64'(0));
    load_measure(555, 0, 0, n);
    check("busy_len_555", 64'(n), 64'(BW));
    cycles(1);
    check("d555", 64'(dig_seg), 64'({P_BLANK, 7'b0010010, 7'b0010010, 7'b0010010}));

    // Load coincident with reset must be dropped.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; value = BW'(321);
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    @(negedge clk);
    check("rst_load_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      load  = 1'b1;
      value = ($urandom_range(0, 1) == 0) ? BW'($urandom_range(0, 9999))
                                          : BW'($urandom_range(0, (1 << BW) - 1));
      @(negedge clk);
      load = 1'b0;
      cycles($urandom_range(0, 22));
    end
    cycles(BW + 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
